// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for the character-RAM port of the video driver.
// Round-robin, one registered grant per cycle, bounded lock for read-modify-write,
// and a tag pipeline that routes read data back to whichever side issued the read.
// A requester whose x_gnt is visible must have dropped or changed x_req by the next edge;
// every sampled x_req is treated as a fresh access.
module vram_port_arbiter #(
  parameter int unsigned AW       = 11,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned HW = $clog2(LOCK_MAX + 1);
  // Last hold value before the lock is forcibly released.
  localparam logic [HW-1:0] HoldLast = HW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {StIdle, StLockA, StLockB} state_e;

  state_e          st_q, st_d;
  logic            last_b_q, last_b_d;  // 1: B was granted most recently
  logic [HW-1:0]   hold_q, hold_d;
  logic            gnt_a_d, gnt_b_d;
  logic [RD_LAT-1:0] tag_v_q;           // read in flight at this stage
  logic [RD_LAT-1:0] tag_b_q;           // owner of that read: 1 = B
  logic [DW-1:0]   a_rdata_q, b_rdata_q;

  // Arbitration decision and lock bookkeeping for the coming edge.
  always_comb begin
    st_d     = st_q;
    last_b_d = last_b_q;
    hold_d   = hold_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    case (st_q)
      StIdle: begin
        if (a_req && (!b_req || last_b_q)) gnt_a_d = 1'b1;
        else if (b_req)                    gnt_b_d = 1'b1;
        if (gnt_a_d && a_lock) begin
          st_d   = StLockA;
          hold_d = HW'(1);
        end
        if (gnt_b_d && b_lock) begin
          st_d   = StLockB;
          hold_d = HW'(1);
        end
      end
      StLockA: begin
        // Owner is served even on its releasing cycle; idle cycles still count toward hold.
        gnt_a_d = a_req;
        if (!a_lock || hold_q == HoldLast) begin
          st_d   = StIdle;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StLockB: begin
        gnt_b_d = b_req;
        if (!b_lock || hold_q == HoldLast) begin
          st_d   = StIdle;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        st_d   = StIdle;
        hold_d = '0;
      end
    endcase
    // The lock owner is always the last grantee, so a forced release hands the next
    // conflict to the other side without extra logic.
    if (gnt_a_d)      last_b_d = 1'b0;
    else if (gnt_b_d) last_b_d = 1'b1;
  end

  // Arbiter state registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q     <= StIdle;
      last_b_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      st_q     <= st_d;
      last_b_q <= last_b_d;
      hold_q   <= hold_d;
    end
  end

  // Registered grant and RAM command; address/data hold when nothing is granted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      a_gnt  <= gnt_a_d;
      b_gnt  <= gnt_b_d;
      mem_we <= (gnt_a_d & a_we) | (gnt_b_d & b_we);
      if (gnt_a_d) begin
        mem_addr  <= a_addr;
        mem_wdata <= a_wdata;
      end else if (gnt_b_d) begin
        mem_addr  <= b_addr;
        mem_wdata <= b_wdata;
      end
    end
  end

  // Read tag pipeline: stage 0 tracks the read on the bus now, the last stage lines up
  // with mem_rdata.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tag_v_q <= '0;
      tag_b_q <= '0;
    end else begin
      tag_v_q[0] <= (a_gnt | b_gnt) & ~mem_we;
      tag_b_q[0] <= b_gnt;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_b_q[i] <= tag_b_q[i-1];
      end
    end
  end

  assign a_rvalid = tag_v_q[RD_LAT-1] & ~tag_b_q[RD_LAT-1];
  assign b_rvalid = tag_v_q[RD_LAT-1] &  tag_b_q[RD_LAT-1];
  assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_q;
  assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_q;

  // Remember the last delivered read data per requester.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end

endmodule
